tensor_register_file: RTL and testbench

Parametrised multi-port register file for the tensor core. It replaces banks of single 8-bit registers with one array of DEPTH entries, each DATA_WIDTH bits wide. It has one write port, NUM_READ_PORTS independent registered read ports, optional write-to-read bypass, and a sequenced bulk-clear engine. It sits between the operand loader and the MAC array, holding operand and accumulator tiles.

---
 rtl/tensor_register_file_pkg.sv | 22 ++
 rtl/tensor_register_file_if.sv | 36 +++
 rtl/tensor_register_file_read_port.sv | 64 ++++++
 rtl/tensor_register_file.sv | 131 +++++++++++++
 tb/tb_tensor_register_file.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tensor_register_file_pkg.sv
// Shared definitions for the tensor core register file: state encoding,
// default geometry and the address-width helper.
package tensor_core_pkg;

    localparam int RF_DATA_WIDTH = 8;
    localparam int RF_DEPTH      = 16;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } rf_state_t;

    // Address width for a given depth; never narrower than one bit so a
    // single-entry file still has a legal address bus.
    function automatic int rf_addr_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/tensor_register_file_if.sv
// Bus between the operand loader / MAC array (master) and the register
// file (slave). Read ports are flattened, port p in slice p of each bus.
interface tensor_register_file_if
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH     = RF_DATA_WIDTH,
    parameter int DEPTH          = RF_DEPTH,
    parameter int NUM_READ_PORTS = 2
) ();

    localparam int ADDR_WIDTH = rf_addr_width(DEPTH);

    logic                                 write_enable;
    logic [ADDR_WIDTH-1:0]                write_address;
    logic [DATA_WIDTH-1:0]                write_data;
    logic [NUM_READ_PORTS-1:0]            read_enable;
    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_address;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [NUM_READ_PORTS-1:0]            read_valid;
    logic                                 clear_start;
    logic                                 busy;
    logic                                 write_error;

    modport master (
        output write_enable, write_address, write_data,
        output read_enable, read_address, clear_start,
        input  read_data, read_valid, busy, write_error
    );

    modport slave (
        input  write_enable, write_address, write_data,
        input  read_enable, read_address, clear_start,
        output read_data, read_valid, busy, write_error
    );

endinterface

// File: rtl/tensor_register_file_read_port.sv
// One registered read port: decides whether the read is accepted, picks the
// stored or forwarded value, and holds the result for one cycle. Output
// data is forced to zero whenever the read is not valid because downstream
// logic ORs several buses together.
module tensor_rf_read_port
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = RF_DEPTH,
    parameter int ADDR_WIDTH = rf_addr_width(RF_DEPTH),
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] entries [DEPTH],
    input  logic                  array_idle,
    input  logic                  clear_start,
    input  logic                  write_accept,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  accept;
    logic                  bypass_hit;
    logic [DATA_WIDTH-1:0] entry_value;
    logic [DATA_WIDTH-1:0] next_data;

    // Select the addressed entry by comparison so an out-of-range address
    // never indexes past the end of the array.
    always_comb begin
        entry_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_address == ADDR_WIDTH'(i)) begin
                entry_value = entries[i];
            end
        end
    end

    // Accept logic and write-to-read forwarding; only accepted writes forward.
    always_comb begin
        accept     = read_enable && array_idle && !clear_start &&
                     ({1'b0, read_address} < DEPTH_LIMIT);
        bypass_hit = (BYPASS != 0) && write_accept && (write_address == read_address);
        next_data  = bypass_hit ? write_data : entry_value;
    end

    // Output register with zero-when-invalid gating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= accept;
            read_data  <= accept ? next_data : '0;
        end
    end

endmodule

// File: rtl/tensor_register_file.sv
// Multi-port register file for the tensor core: one write port, a set of
// independent registered read ports and a one-entry-per-cycle clear engine.
module tensor_register_file
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH     = RF_DATA_WIDTH,
    parameter int DEPTH          = RF_DEPTH,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYPASS         = 1
) (
    input logic                   clock,
    input logic                   reset_n,
    tensor_register_file_if.slave bus
);

    localparam int                  ADDR_WIDTH  = rf_addr_width(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [0:0]          ST_IDLE     = IDLE;
    localparam logic [0:0]          ST_CLEARING = CLEARING;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clear_index;
    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic                  array_idle;
    logic                  write_in_range;
    logic                  write_accept;
    logic                  write_drop;
    logic [DATA_WIDTH-1:0] port_data [NUM_READ_PORTS];
    logic                  port_valid [NUM_READ_PORTS];

    // Writes land only while idle and not competing with a clear request.
    always_comb begin
        array_idle     = (state == ST_IDLE);
        write_in_range = ({1'b0, bus.write_address} < DEPTH_LIMIT);
        write_accept   = bus.write_enable && array_idle && !bus.clear_start && write_in_range;
        write_drop     = bus.write_enable && !write_accept;
    end

    // Clear sequencer: walks clear_index from 0 to DEPTH-1 and stops exactly
    // at the last entry, so non-power-of-two depths never wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            clear_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clear_start) begin
                        state       <= ST_CLEARING;
                        clear_index <= '0;
                    end
                end
                ST_CLEARING: begin
                    if (clear_index == LAST_INDEX) begin
                        state       <= ST_IDLE;
                        clear_index <= '0;
                    end else begin
                        clear_index <= clear_index + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    clear_index <= '0;
                end
            endcase
        end
    end

    // Storage array: the clear engine owns the array while running,
    // otherwise an accepted write updates its one entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((state == ST_CLEARING) && (clear_index == ADDR_WIDTH'(i))) begin
                    entries[i] <= '0;
                end else if (write_accept && (bus.write_address == ADDR_WIDTH'(i))) begin
                    entries[i] <= bus.write_data;
                end
            end
        end
    end

    // One-cycle pulse flagging a dropped write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.write_error <= 1'b0;
        end else begin
            bus.write_error <= write_drop;
        end
    end

    assign bus.busy = (state == ST_CLEARING);

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read_port
        tensor_rf_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYPASS     (BYPASS)
        ) u_read_port (
            .clock         (clock),
            .reset_n       (reset_n),
            .read_enable   (bus.read_enable[p]),
            .read_address  (bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .entries       (entries),
            .array_idle    (array_idle),
            .clear_start   (bus.clear_start),
            .write_accept  (write_accept),
            .write_address (bus.write_address),
            .write_data    (bus.write_data),
            .read_data     (port_data[p]),
            .read_valid    (port_valid[p])
        );
    end

    // Pack the per-port results onto the flattened output buses.
    always_comb begin
        bus.read_data  = '0;
        bus.read_valid = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = port_data[p];
            bus.read_valid[p]                         = port_valid[p];
        end
    end

endmodule

// File: tb/tb_tensor_register_file.sv
// Directed bench for tensor_register_file: a 16-entry bypassing file (main),
// a 16-entry non-bypassing file and a 10-entry file share one stimulus.
module tb_tensor_register_file;

    logic clock;
    logic reset_n;
    int   num_compared;
    int   num_mismatched;

    tensor_register_file_if #(.DATA_WIDTH(8), .DEPTH(16), .NUM_READ_PORTS(2)) bus_a ();
    tensor_register_file_if #(.DATA_WIDTH(8), .DEPTH(16), .NUM_READ_PORTS(2)) bus_b ();
    tensor_register_file_if #(.DATA_WIDTH(8), .DEPTH(10), .NUM_READ_PORTS(2)) bus_c ();

    tensor_register_file #(.DATA_WIDTH(8), .DEPTH(16), .NUM_READ_PORTS(2), .BYPASS(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    tensor_register_file #(.DATA_WIDTH(8), .DEPTH(16), .NUM_READ_PORTS(2), .BYPASS(0)) dut_nb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    tensor_register_file #(.DATA_WIDTH(8), .DEPTH(10), .NUM_READ_PORTS(2), .BYPASS(1)) dut_small (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_c)
    );

    assign bus_b.write_enable  = bus_a.write_enable;
    assign bus_b.write_address = bus_a.write_address;
    assign bus_b.write_data    = bus_a.write_data;
    assign bus_b.read_enable   = bus_a.read_enable;
    assign bus_b.read_address  = bus_a.read_address;
    assign bus_b.clear_start   = bus_a.clear_start;
    assign bus_c.write_enable  = bus_a.write_enable;
    assign bus_c.write_address = bus_a.write_address;
    assign bus_c.write_data    = bus_a.write_data;
    assign bus_c.read_enable   = bus_a.read_enable;
    assign bus_c.read_address  = bus_a.read_address;
    assign bus_c.clear_start   = bus_a.clear_start;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [1:0] re;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic       cs;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
        logic [1:0] exp_v;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    vec_t vectors [12];

    // Drive one cycle of inputs at a falling edge, let one rising edge pass,
    // and return at the next falling edge where outputs are stable.
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                 input logic [1:0] re, input logic [3:0] ra0,
                                 input logic [3:0] ra1, input logic cs);
        bus_a.write_enable  = we;
        bus_a.write_address = wa;
        bus_a.write_data    = wd;
        bus_a.read_enable   = re;
        bus_a.read_address  = {ra1, ra0};
        bus_a.clear_start   = cs;
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkMain(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [1:0] v, input logic err, input logic busy);
        checkOutput({tag, ".read_data0"},  16'(bus_a.read_data[7:0]),  16'(d0));
        checkOutput({tag, ".read_data1"},  16'(bus_a.read_data[15:8]), 16'(d1));
        checkOutput({tag, ".read_valid"},  16'(bus_a.read_valid),      16'(v));
        checkOutput({tag, ".write_error"}, 16'(bus_a.write_error),     16'(err));
        checkOutput({tag, ".busy"},        16'(bus_a.busy),            16'(busy));
    endtask

    // Clear with dropped writes and blocked reads for the first cycles;
    // main must stay busy for 16 cycles, the 10-entry file for 10.
    task automatic runClear(input string tag);
        int main_busy_cycles;
        int small_busy_cycles;
        applyStimulus(1'b1, 4'd0, 8'h77, 2'b00, 4'd0, 4'd0, 1'b1);
        checkOutput({tag, ".start.busy"},        16'(bus_a.busy),        16'd1);
        checkOutput({tag, ".start.write_error"}, 16'(bus_a.write_error), 16'd1);
        main_busy_cycles  = bus_a.busy ? 1 : 0;
        small_busy_cycles = bus_c.busy ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(logic'(c < 3), 4'd2, 8'h55, 2'b11, 4'd1, 4'd1, 1'b0);
            checkOutput($sformatf("%s.c%0d.busy", tag, c), 16'(bus_a.busy), 16'(c < 15));
            checkOutput($sformatf("%s.c%0d.write_error", tag, c), 16'(bus_a.write_error), 16'(c < 3));
            checkOutput($sformatf("%s.c%0d.read_valid", tag, c), 16'(bus_a.read_valid),
                        (c >= 16) ? 16'h3 : 16'h0);
            checkOutput($sformatf("%s.c%0d.read_data", tag, c), bus_a.read_data, 16'h0);
            checkOutput($sformatf("%s.c%0d.small_busy", tag, c), 16'(bus_c.busy), 16'(c < 9));
            if (bus_a.busy) main_busy_cycles++;
            if (bus_c.busy) small_busy_cycles++;
        end
        checkOutput({tag, ".main_busy_cycles"},  16'(main_busy_cycles),  16'd16);
        checkOutput({tag, ".small_busy_cycles"}, 16'(small_busy_cycles), 16'd10);
    endtask

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        reset_n = 1'b0;
        bus_a.write_enable  = 1'b0;
        bus_a.write_address = '0;
        bus_a.write_data    = '0;
        bus_a.read_enable   = '0;
        bus_a.read_address  = '0;
        bus_a.clear_start   = 1'b0;

        //           we  wa     wd     re     ra0    ra1    cs    d0     d1     v      err   busy
        vectors[0]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd0,  4'd15, 1'b0, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0};
        vectors[1]  = '{1'b1, 4'd3,  8'hA5, 2'b00, 4'd0,  4'd0,  1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0};
        vectors[2]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd3,  4'd4,  1'b0, 8'hA5, 8'h00, 2'b11, 1'b0, 1'b0};
        vectors[3]  = '{1'b0, 4'd0,  8'h00, 2'b00, 4'd3,  4'd4,  1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0};
        vectors[4]  = '{1'b1, 4'd7,  8'h11, 2'b01, 4'd3,  4'd0,  1'b0, 8'hA5, 8'h00, 2'b01, 1'b0, 1'b0};
        vectors[5]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd7,  4'd7,  1'b0, 8'h11, 8'h11, 2'b11, 1'b0, 1'b0};
        vectors[6]  = '{1'b1, 4'd15, 8'h99, 2'b10, 4'd0,  4'd3,  1'b0, 8'h00, 8'hA5, 2'b10, 1'b0, 1'b0};
        vectors[7]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd15, 4'd3,  1'b0, 8'h99, 8'hA5, 2'b11, 1'b0, 1'b0};
        vectors[8]  = '{1'b1, 4'd3,  8'h5A, 2'b01, 4'd3,  4'd0,  1'b0, 8'h5A, 8'h00, 2'b01, 1'b0, 1'b0};
        vectors[9]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd3,  4'd3,  1'b0, 8'h5A, 8'h5A, 2'b11, 1'b0, 1'b0};
        vectors[10] = '{1'b1, 4'd4,  8'hC3, 2'b10, 4'd0,  4'd3,  1'b0, 8'h00, 8'h5A, 2'b10, 1'b0, 1'b0};
        vectors[11] = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd4,  4'd0,  1'b0, 8'hC3, 8'h00, 2'b11, 1'b0, 1'b0};

        repeat (3) @(negedge clock);
        checkMain("reset.main", 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        checkOutput("reset.nb.read_valid", 16'(bus_b.read_valid), 16'h0);
        checkOutput("reset.small.busy",    16'(bus_c.busy),       16'h0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vectors[i].we, vectors[i].wa, vectors[i].wd, vectors[i].re,
                          vectors[i].ra0, vectors[i].ra1, vectors[i].cs);
            checkMain($sformatf("vec%0d", i), vectors[i].exp_d0, vectors[i].exp_d1,
                      vectors[i].exp_v, vectors[i].exp_err, vectors[i].exp_busy);
        end

        // Same-cycle write and read of address 7 (old value 0x11).
        applyStimulus(1'b1, 4'd7, 8'h3C, 2'b11, 4'd7, 4'd7, 1'b0);
        checkOutput("bypass.main.read_data", bus_a.read_data, 16'h3C3C);
        checkOutput("bypass.nb.read_data",   bus_b.read_data, 16'h1111);
        checkOutput("bypass.nb.read_valid",  16'(bus_b.read_valid), 16'h3);
        applyStimulus(1'b0, 4'd0, 8'h00, 2'b11, 4'd7, 4'd7, 1'b0);
        checkOutput("bypass.after.main", bus_a.read_data, 16'h3C3C);
        checkOutput("bypass.after.nb",   bus_b.read_data, 16'h3C3C);

        // Fill, clear, then confirm every main entry reads back zero.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 8'hFF, 2'b00, 4'd0, 4'd0, 1'b0);
            checkOutput($sformatf("fill%0d.write_error", i), 16'(bus_a.write_error), 16'h0);
        end
        applyStimulus(1'b0, 4'd0, 8'h00, 2'b11, 4'd9, 4'd15, 1'b0);
        checkOutput("fill.readback", bus_a.read_data, 16'hFFFF);
        runClear("clear");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'd0, 8'h00, 2'b11, 4'(i), 4'(15 - i), 1'b0);
            checkMain($sformatf("cleared%0d", i), 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
        end

        // Out-of-range address on the 10-entry file.
        applyStimulus(1'b1, 4'd12, 8'h66, 2'b00, 4'd0, 4'd0, 1'b0);
        checkOutput("small.oor.write_error", 16'(bus_c.write_error), 16'h1);
        checkOutput("main.a12.write_error",  16'(bus_a.write_error), 16'h0);
        applyStimulus(1'b0, 4'd0, 8'h00, 2'b11, 4'd12, 4'd9, 1'b0);
        checkOutput("small.oor.read_valid",  16'(bus_c.read_valid),  16'h2);
        checkOutput("small.oor.read_data",   bus_c.read_data,        16'h0);
        checkOutput("small.oor.err_pulse",   16'(bus_c.write_error), 16'h0);
        checkOutput("main.a12.read_data",    bus_a.read_data,        16'h0066);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'd0, 8'h00, 2'b11, 4'(2 * i), 4'(2 * i + 1), 1'b0);
            checkOutput($sformatf("small.entries%0d.data", i),  bus_c.read_data,        16'h0);
            checkOutput($sformatf("small.entries%0d.valid", i), 16'(bus_c.read_valid),  16'h3);
        end

        // Reset in the fifth clear cycle aborts the clear and zeroes the array.
        applyStimulus(1'b1, 4'd5, 8'h42, 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd0, 8'h77, 2'b00, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'd9, 8'h88, 2'b11, 4'd5, 4'd12, 1'b0);
        end
        checkOutput("midreset.pre.busy",        16'(bus_a.busy),        16'h1);
        checkOutput("midreset.pre.write_error", 16'(bus_a.write_error), 16'h1);
        reset_n = 1'b0;
        #2;
        checkMain("midreset.async", 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        checkOutput("midreset.small.busy", 16'(bus_c.busy), 16'h0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 8'h00, 2'b11, 4'd5, 4'd12, 1'b0);
        checkMain("midreset.zeroed", 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
        runClear("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
